// File: rtl/sccb_pkg.sv
// sccb_pkg: shared types and constants for the SCCB register target.
// FSM encoding, ACK/NACK bus levels and default camera device IDs.
package sccb_pkg;

  typedef enum logic [3:0] {
    IDLE,
    DEV_ADDR,
    DEV_ACK,
    ADDR_HI,
    ADDR_HI_ACK,
    ADDR_LO,
    ADDR_LO_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK
  } sccb_state_e;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  localparam logic [7:0] OV5640_ID = 8'h78;
  localparam logic [7:0] OV7725_ID = 8'h42;

endpackage

// File: rtl/sccb_in_filter.sv
// sccb_in_filter: 2-FF synchronizer plus stability filter for one bus line.
// A new level is accepted only after FILT_LEN consecutive stable Clk cycles.
module sccb_in_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic in_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = $clog2(FILT_LEN + 1);

  logic          s1_q;
  logic          s2_q;
  logic          lvl_q;
  logic          rise_q;
  logic          fall_q;
  logic [CW-1:0] cnt_q;

  // Idle bus level is high, so reset to 1 to avoid a spurious edge.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      lvl_q  <= 1'b1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= in_i;
      s2_q   <= s1_q;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (s2_q == lvl_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILT_LEN - 1)) begin
        lvl_q  <= s2_q;
        rise_q <= s2_q;
        fall_q <= ~s2_q;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign lvl_o  = lvl_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/sccb_target_regs.sv
// sccb_target_regs: SCCB/I2C target driving a simple register-file port.
// Filters SCL/SDA, decodes START/STOP, handles write bursts and reads.
module sccb_target_regs
  import sccb_pkg::*;
#(
  parameter logic [7:0] DEVICE_ID = OV5640_ID,
  parameter bit         ADDR_MODE = 1'b1,
  parameter int         FILT_LEN  = 3
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        i2c_sclk,
  inout  wire         i2c_sdat,
  output logic [15:0] reg_addr,
  output logic        reg_wr_en,
  output logic [7:0]  reg_wdata,
  output logic        reg_rd_en,
  input  logic [7:0]  reg_rdata,
  output logic        busy,
  output logic [7:0]  nack_cnt
);

  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;

  sccb_in_filter #(.FILT_LEN(FILT_LEN)) u_scl (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .in_i   (i2c_sclk),
    .lvl_o  (scl),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  sccb_in_filter #(.FILT_LEN(FILT_LEN)) u_sda (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .in_i   (i2c_sdat),
    .lvl_o  (sda),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  sccb_state_e state_q;
  logic [3:0]  bit_q;
  logic [7:0]  sh_q;
  logic        sda_oe_q;
  logic        rnw_q;
  logic [15:0] addr_q;
  logic        wr_q;
  logic [7:0]  wd_q;
  logic        rd_q;
  logic        ld_q;
  logic        busy_q;
  logic [7:0]  nack_q;

  logic        start_ev, stop_ev;
  logic        last_d;
  logic [7:0]  rx_d;
  logic [15:0] addr_inc_d;
  sccb_state_e ack_nxt_d;

  assign start_ev = sda_fall & scl;
  assign stop_ev  = sda_rise & scl;
  assign rx_d     = {sh_q[6:0], sda};
  assign last_d   = scl_rise & (bit_q == 4'd7);

  assign addr_inc_d = ADDR_MODE ? addr_q + 16'd1
                                : {8'h00, addr_q[7:0] + 8'd1};

  always_comb begin
    ack_nxt_d = WR_DATA;
    case (state_q)
      DEV_ACK:     ack_nxt_d = rnw_q ? RD_DATA
                             : (ADDR_MODE ? ADDR_HI : ADDR_LO);
      ADDR_HI_ACK: ack_nxt_d = ADDR_LO;
      default:     ack_nxt_d = WR_DATA;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= IDLE;
      bit_q    <= '0;
      sh_q     <= '0;
      sda_oe_q <= 1'b0;
      rnw_q    <= 1'b0;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      wd_q     <= '0;
      rd_q     <= 1'b0;
      ld_q     <= 1'b0;
      busy_q   <= 1'b0;
      nack_q   <= '0;
    end else begin
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      ld_q <= rd_q;
      // Read byte arrives one Clk after the strobe; present bit 7 at once.
      if (ld_q && state_q == RD_DATA) begin
        sh_q     <= reg_rdata;
        sda_oe_q <= ~reg_rdata[7];
      end
      if (start_ev) begin
        state_q  <= DEV_ADDR;
        bit_q    <= '0;
        sda_oe_q <= 1'b0;
      end else if (stop_ev) begin
        state_q  <= IDLE;
        bit_q    <= '0;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        unique case (state_q)
          DEV_ADDR, ADDR_HI, ADDR_LO, WR_DATA: begin
            if (scl_rise) begin
              sh_q  <= rx_d;
              bit_q <= bit_q + 4'd1;
            end
            if (last_d) begin
              unique case (state_q)
                DEV_ADDR: begin
                  if (rx_d[7:1] != DEVICE_ID[7:1]) begin
                    state_q <= IDLE;
                  end else begin
                    busy_q  <= 1'b1;
                    rnw_q   <= rx_d[0];
                    state_q <= DEV_ACK;
                  end
                end
                ADDR_HI: begin
                  addr_q[15:8] <= rx_d;
                  state_q      <= ADDR_HI_ACK;
                end
                ADDR_LO: begin
                  addr_q  <= ADDR_MODE ? {addr_q[15:8], rx_d}
                                       : {8'h00, rx_d};
                  state_q <= ADDR_LO_ACK;
                end
                default: begin
                  wr_q    <= 1'b1;
                  wd_q    <= rx_d;
                  state_q <= WR_ACK;
                end
              endcase
            end
          end
          DEV_ACK, ADDR_HI_ACK, ADDR_LO_ACK, WR_ACK: begin
            if (scl_fall) begin
              if (bit_q == 4'd8) begin
                sda_oe_q <= 1'b1;
                bit_q    <= 4'd9;
              end else begin
                sda_oe_q <= 1'b0;
                bit_q    <= '0;
                state_q  <= ack_nxt_d;
                if (state_q == WR_ACK) addr_q <= addr_inc_d;
                if (ack_nxt_d == RD_DATA) rd_q <= 1'b1;
              end
            end
          end
          RD_DATA: begin
            if (scl_fall) begin
              if (bit_q == 4'd7) begin
                sda_oe_q <= 1'b0;
                bit_q    <= '0;
                state_q  <= RD_ACK;
              end else begin
                sh_q     <= {sh_q[6:0], sh_q[7]};
                sda_oe_q <= ~sh_q[6];
                bit_q    <= bit_q + 4'd1;
              end
            end
          end
          RD_ACK: begin
            if (scl_rise && sda == NACK) begin
              nack_q  <= nack_q + {7'd0, nack_q != 8'hFF};
              state_q <= IDLE;
            end else if (scl_fall) begin
              addr_q  <= addr_inc_d;
              rd_q    <= 1'b1;
              bit_q   <= '0;
              state_q <= RD_DATA;
            end
          end
          IDLE: ;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign i2c_sdat  = sda_oe_q ? 1'b0 : 1'bz;
  assign reg_addr  = addr_q;
  assign reg_wr_en = wr_q;
  assign reg_wdata = wd_q;
  assign reg_rd_en = rd_q;
  assign busy      = busy_q;
  assign nack_cnt  = nack_q;

endmodule

// File: tb/tb_sccb_target_regs.sv
// tb_sccb_target_regs: bus-master stimulus for two SCCB targets on one bus.
// Register strobes are checked against queued expectations by monitors.
module tb_sccb_target_regs;
  import sccb_pkg::*;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  logic scl   = 1'b1;
  logic m_oe  = 1'b0;
  wire  sda;

  assign sda = m_oe ? 1'b0 : 1'bz;
  pullup (sda);

  logic [15:0] a_addr, b_addr;
  logic        a_wr, b_wr, a_rd, b_rd, a_busy, b_busy;
  logic [7:0]  a_wd, b_wd, a_nack, b_nack, a_rdata, b_rdata;

  sccb_target_regs u_a (
    .Clk       (Clk),
    .Rst_n     (rst_a),
    .i2c_sclk  (scl),
    .i2c_sdat  (sda),
    .reg_addr  (a_addr),
    .reg_wr_en (a_wr),
    .reg_wdata (a_wd),
    .reg_rd_en (a_rd),
    .reg_rdata (a_rdata),
    .busy      (a_busy),
    .nack_cnt  (a_nack)
  );

  sccb_target_regs #(
    .DEVICE_ID (OV7725_ID),
    .ADDR_MODE (1'b0),
    .FILT_LEN  (3)
  ) u_b (
    .Clk       (Clk),
    .Rst_n     (rst_b),
    .i2c_sclk  (scl),
    .i2c_sdat  (sda),
    .reg_addr  (b_addr),
    .reg_wr_en (b_wr),
    .reg_wdata (b_wd),
    .reg_rd_en (b_rd),
    .reg_rdata (b_rdata),
    .busy      (b_busy),
    .nack_cnt  (b_nack)
  );

  always_comb begin
    case (a_addr)
      16'h300A: a_rdata = 8'h56;
      16'h300B: a_rdata = 8'h40;
      default:  a_rdata = 8'hEE;
    endcase
  end
  assign b_rdata = 8'h5A;

  int checks = 0;
  int errors = 0;
  logic [23:0] qa[$];
  logic [23:0] qb[$];
  logic [15:0] qra[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (a_wr) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL wr_a unexpected got=%h", {a_addr, a_wd});
      end else begin
        chk("wr_a", 32'({a_addr, a_wd}), 32'(qa.pop_front()));
      end
    end
    if (b_wr) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL wr_b unexpected got=%h", {b_addr, b_wd});
      end else begin
        chk("wr_b", 32'({b_addr, b_wd}), 32'(qb.pop_front()));
      end
    end
    if (a_rd) begin
      if (qra.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_a unexpected got=%h", a_addr);
      end else begin
        chk("rd_a", 32'(a_addr), 32'(qra.pop_front()));
      end
    end
    if (b_rd) begin
      checks++; errors++;
      $display("FAIL rd_b unexpected got=%h", b_addr);
    end
  end

  task automatic hq();
    repeat (10) @(posedge Clk);
    #1;
  endtask

  task automatic start_c();
    m_oe = 1'b0; hq();
    scl  = 1'b1; hq();
    m_oe = 1'b1; hq();
    scl  = 1'b0; hq();
  endtask

  task automatic stop_c();
    m_oe = 1'b1; hq();
    scl  = 1'b1; hq();
    m_oe = 1'b0; hq();
    hq();
  endtask

  task automatic bit_w(input logic b, input logic g, output logic r);
    m_oe = ~b;
    if (g) begin
      repeat (3) @(posedge Clk);
      #1 scl = 1'b1;
      @(posedge Clk);
      #1 scl = 1'b0;
    end
    hq();
    scl = 1'b1; hq();
    r   = sda;  hq();
    scl = 1'b0; hq();
  endtask

  task automatic wbyte(input logic [7:0] d, input logic [7:0] gm,
                       output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_w(d[i], gm[i], r);
    bit_w(1'b1, 1'b0, r);
    ack = r;
  endtask

  task automatic rbyte(input logic ackb, output logic [7:0] d);
    logic r;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      bit_w(1'b1, 1'b0, r);
      d = {d[6:0], r};
    end
    bit_w(ackb, 1'b0, r);
  endtask

  logic       ack, r;
  logic [7:0] rd;

  initial begin
    repeat (5) @(posedge Clk);
    #1;
    chk("rst_addr", 32'(a_addr), 32'h0);
    chk("rst_wr", 32'(a_wr), 32'h0);
    chk("rst_busy", 32'(a_busy), 32'h0);
    chk("rst_nack", 32'(a_nack), 32'h0);
    chk("rst_sda", 32'(sda), 32'h1);
    rst_a = 1'b1;
    hq();

    // single write 0x3008 <= 0x82
    start_c();
    wbyte(8'h78, 8'h00, ack); chk("t1_ack_dev", 32'(ack), 32'h0);
    chk("t1_busy", 32'(a_busy), 32'h1);
    wbyte(8'h30, 8'h00, ack); chk("t1_ack_hi", 32'(ack), 32'h0);
    wbyte(8'h08, 8'h00, ack); chk("t1_ack_lo", 32'(ack), 32'h0);
    qa.push_back({16'h3008, 8'h82});
    wbyte(8'h82, 8'h00, ack); chk("t1_ack_dat", 32'(ack), 32'h0);
    stop_c();
    chk("t1_busy_off", 32'(a_busy), 32'h0);

    // burst write from 0x3100
    start_c();
    wbyte(8'h78, 8'h00, ack); chk("t2_ack_dev", 32'(ack), 32'h0);
    wbyte(8'h31, 8'h00, ack); chk("t2_ack_hi", 32'(ack), 32'h0);
    wbyte(8'h00, 8'h00, ack); chk("t2_ack_lo", 32'(ack), 32'h0);
    qa.push_back({16'h3100, 8'h11});
    qa.push_back({16'h3101, 8'h22});
    qa.push_back({16'h3102, 8'h33});
    wbyte(8'h11, 8'h00, ack); chk("t2_ack_d0", 32'(ack), 32'h0);
    wbyte(8'h22, 8'h00, ack); chk("t2_ack_d1", 32'(ack), 32'h0);
    wbyte(8'h33, 8'h00, ack); chk("t2_ack_d2", 32'(ack), 32'h0);
    stop_c();
    chk("t2_addr", 32'(a_addr), 32'h3103);

    // combined read of 0x300A, 0x300B
    start_c();
    wbyte(8'h78, 8'h00, ack); chk("t3_ack_dev", 32'(ack), 32'h0);
    wbyte(8'h30, 8'h00, ack); chk("t3_ack_hi", 32'(ack), 32'h0);
    wbyte(8'h0A, 8'h00, ack); chk("t3_ack_lo", 32'(ack), 32'h0);
    start_c();
    qra.push_back(16'h300A);
    qra.push_back(16'h300B);
    wbyte(8'h79, 8'h00, ack); chk("t3_ack_rd", 32'(ack), 32'h0);
    rbyte(1'b0, rd); chk("t3_byte0", 32'(rd), 32'h56);
    rbyte(1'b1, rd); chk("t3_byte1", 32'(rd), 32'h40);
    stop_c();
    chk("t3_nack", 32'(a_nack), 32'h1);
    chk("t3_busy_off", 32'(a_busy), 32'h0);

    // foreign device ID is ignored
    start_c();
    wbyte(8'h42, 8'h00, ack); chk("t4_noack", 32'(ack), 32'h1);
    chk("t4_busy", 32'(a_busy), 32'h0);
    wbyte(8'h55, 8'h00, ack); chk("t4_noack2", 32'(ack), 32'h1);
    stop_c();

    // 8-bit address target, wrap FF -> 00
    rst_b = 1'b1;
    hq();
    start_c();
    wbyte(8'h42, 8'h00, ack); chk("t5_ack_dev", 32'(ack), 32'h0);
    chk("t5_a_idle", 32'(a_busy), 32'h0);
    wbyte(8'h12, 8'h00, ack); chk("t5_ack_lo", 32'(ack), 32'h0);
    qb.push_back({16'h0012, 8'h80});
    wbyte(8'h80, 8'h00, ack); chk("t5_ack_dat", 32'(ack), 32'h0);
    stop_c();
    start_c();
    wbyte(8'h42, 8'h00, ack); chk("t5_ack_dev2", 32'(ack), 32'h0);
    wbyte(8'hFF, 8'h00, ack); chk("t5_ack_lo2", 32'(ack), 32'h0);
    qb.push_back({16'h00FF, 8'hA1});
    qb.push_back({16'h0000, 8'hA2});
    wbyte(8'hA1, 8'h00, ack); chk("t5_ack_d0", 32'(ack), 32'h0);
    wbyte(8'hA2, 8'h00, ack); chk("t5_ack_d1", 32'(ack), 32'h0);
    stop_c();
    chk("t5_addr", 32'(b_addr), 32'h0001);
    chk("t5_busy_off", 32'(b_busy), 32'h0);

    // reset during ADDR_LO bit 4, then a glitched but clean write
    start_c();
    wbyte(8'h78, 8'h00, ack); chk("t6_ack_dev", 32'(ack), 32'h0);
    wbyte(8'h30, 8'h00, ack); chk("t6_ack_hi", 32'(ack), 32'h0);
    for (int i = 0; i < 3; i++) bit_w(1'b0, 1'b0, r);
    m_oe = 1'b0; hq();
    scl  = 1'b1;
    repeat (4) @(posedge Clk);
    #1 rst_a = 1'b0;
    @(posedge Clk);
    #1;
    chk("t6_rst_sda", 32'(sda), 32'h1);
    chk("t6_rst_busy", 32'(a_busy), 32'h0);
    chk("t6_rst_addr", 32'(a_addr), 32'h0);
    repeat (3) @(posedge Clk);
    #1 rst_a = 1'b1;
    hq();
    scl = 1'b0; hq();
    stop_c();
    start_c();
    wbyte(8'h78, 8'h00, ack); chk("t6_ack_dev2", 32'(ack), 32'h0);
    wbyte(8'h31, 8'h00, ack); chk("t6_ack_hi2", 32'(ack), 32'h0);
    wbyte(8'h05, 8'h00, ack); chk("t6_ack_lo2", 32'(ack), 32'h0);
    qa.push_back({16'h3105, 8'h99});
    wbyte(8'h99, 8'h18, ack); chk("t6_ack_dat", 32'(ack), 32'h0);
    stop_c();
    chk("t6_addr", 32'(a_addr), 32'h3106);

    hq();
    chk("qa_empty", 32'(qa.size()), 32'h0);
    chk("qb_empty", 32'(qb.size()), 32'h0);
    chk("qra_empty", 32'(qra.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
